// File: rtl/fetch_stage.sv
// Fetch stage of the 5-stage MIPS pipeline.
// Holds the PC register, derives the instruction-memory word address and the
// fetch-error flag from it, and owns the F/D pipeline register that launches
// {D_PC, D_Instr} into Decode. A single stall freezes PC and F/D together.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_DEPTH = 4096,
    parameter int unsigned IM_AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [31:0]      npc,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_rdata,
    output logic [31:0]      F_PC,
    output logic             F_pc_err,
    output logic [31:0]      D_PC,
    output logic [31:0]      D_Instr,
    output logic             D_valid,
    output logic             D_pc_err,
    output logic [31:0]      fetch_cnt
);

    // Size of the instruction-memory window in bytes, kept 33 bits wide so a
    // window reaching the top of the address space does not wrap to zero.
    localparam logic [32:0] IM_SIZE = 33'(IM_DEPTH) << 2;

    logic [31:0] pc_q,    pc_d;
    logic [31:0] dpc_q,   dpc_d;
    logic [31:0] dins_q,  dins_d;
    logic        dval_q,  dval_d;
    logic        derr_q,  derr_d;
    logic [31:0] cnt_q,   cnt_d;

    logic [31:0] pc_off;
    logic        misaligned;
    logic        below_base;
    logic        above_top;

    // Byte offset of the fetch PC into the instruction-memory window.
    assign pc_off  = pc_q - IM_BASE;
    assign im_addr = pc_off[IM_AW+1:2];

    // Upper bound checked on the offset rather than on F_PC: once F_PC >= IM_BASE
    // the offset is exact, so offset >= size is the same as the 33-bit compare
    // F_PC >= IM_BASE + size, without building a 33-bit adder on the PC.
    assign misaligned = |pc_q[1:0];
    assign below_base = pc_q < IM_BASE;
    assign above_top  = {1'b0, pc_off} >= IM_SIZE;
    assign F_pc_err   = misaligned | below_base | above_top;

    // Next-state for PC and F/D: everything advances together unless stalled.
    always_comb begin
        pc_d   = pc_q;
        dpc_d  = dpc_q;
        dins_d = dins_q;
        dval_d = dval_q;
        derr_d = derr_q;
        cnt_d  = cnt_q;
        if (!stall) begin
            pc_d   = npc;
            dpc_d  = pc_q;
            dins_d = F_pc_err ? '0 : im_rdata;
            dval_d = 1'b1;
            derr_d = F_pc_err;
            cnt_d  = cnt_q + 32'd1;
        end
    end

    // PC and F/D registers; synchronous reset has priority over stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= PC_RESET;
            dpc_q  <= '0;
            dins_q <= '0;
            dval_q <= 1'b0;
            derr_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            dpc_q  <= dpc_d;
            dins_q <= dins_d;
            dval_q <= dval_d;
            derr_q <= derr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign F_PC      = pc_q;
    assign D_PC      = dpc_q;
    assign D_Instr   = dins_q;
    assign D_valid   = dval_q;
    assign D_pc_err  = derr_q;
    assign fetch_cnt = cnt_q;

endmodule
